// File: rtl/pb_cmd_sched.sv
// Pushbutton command scheduler: latches release pulses into pending flags,
// grants them round-robin as valid/ready commands with an enforced idle gap,
// toggles the power state on button-0 commands and counts lost releases.
module pb_cmd_sched #(
    parameter int unsigned NUM_PB     = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PB-1:0]         rel,
    input  logic                      cmd_rdy,
    output logic                      cmd_vld,
    output logic [$clog2(NUM_PB)-1:0] cmd_id,
    output logic [NUM_PB-1:0]         pend,
    output logic                      pwr_up,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned IdW = $clog2(NUM_PB);

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic              cmd_vld_q, cmd_vld_d;
    logic [IdW-1:0]    cmd_id_q, cmd_id_d;
    logic [NUM_PB-1:0] pend_q, pend_d;
    logic              pwr_up_q, pwr_up_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [IdW-1:0]    rr_last_q, rr_last_d;
    logic [7:0]        gap_q, gap_d;

    logic              accept;
    logic [NUM_PB-1:0] clr_mask;
    logic              drop_any;
    logic              win_found;
    logic [IdW-1:0]    win_id;
    logic [IdW-1:0]    idx;

    // Round-robin search over the registered pending flags, starting after rr_last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_PB; k++) begin
            idx = IdW'((32'(rr_last_q) + k) % NUM_PB);
            if (!win_found && pend_q[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Next-state for pending flags, drop counter and the command FSM.
    always_comb begin
        accept     = cmd_vld_q & cmd_rdy;
        clr_mask   = accept ? ({{(NUM_PB-1){1'b0}}, 1'b1} << cmd_id_q) : '0;
        // A release on the accepting edge of the same button is a fresh event.
        drop_any   = |(rel & pend_q & ~clr_mask);
        pend_d     = (pend_q & ~clr_mask) | rel;
        drop_cnt_d = (drop_any && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

        state_d    = state_q;
        cmd_vld_d  = cmd_vld_q;
        cmd_id_d   = cmd_id_q;
        pwr_up_d   = pwr_up_q;
        rr_last_d  = rr_last_q;
        gap_d      = gap_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    cmd_vld_d = 1'b1;
                    cmd_id_d  = win_id;
                    state_d   = StOffer;
                end
            end
            StOffer: begin
                if (cmd_rdy) begin
                    cmd_vld_d = 1'b0;
                    rr_last_d = cmd_id_q;
                    if (cmd_id_q == '0) begin
                        pwr_up_d = ~pwr_up_q;
                    end
                    if (GAP_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        gap_d   = 8'(GAP_CYCLES - 1);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; all outputs come straight from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cmd_vld_q  <= 1'b0;
            cmd_id_q   <= '0;
            pend_q     <= '0;
            pwr_up_q   <= 1'b0;
            drop_cnt_q <= 8'd0;
            rr_last_q  <= IdW'(NUM_PB - 1);
            gap_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_id_q   <= cmd_id_d;
            pend_q     <= pend_d;
            pwr_up_q   <= pwr_up_d;
            drop_cnt_q <= drop_cnt_d;
            rr_last_q  <= rr_last_d;
            gap_q      <= gap_d;
        end
    end

    assign cmd_vld  = cmd_vld_q;
    assign cmd_id   = cmd_id_q;
    assign pend     = pend_q;
    assign pwr_up   = pwr_up_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pb_cmd_sched.sv
// Bench for pb_cmd_sched: directed scenarios plus random traffic, all checked
// against a cycle-count based reference model of the scheduler.
module tb_pb_cmd_sched;

    localparam int unsigned Num = 4;
    localparam int unsigned Gap = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rel;
    logic       cmd_rdy;
    logic       cmd_vld;
    logic [1:0] cmd_id;
    logic [3:0] pend;
    logic       pwr_up;
    logic [7:0] drop_cnt;

    // Second instance with no gap, used only for the back-to-back pattern.
    logic [3:0] rel0;
    logic       rdy0;
    logic       vld0;
    logic [1:0] id0;
    logic [3:0] pend0;
    logic       pwr0;
    logic [7:0] drop0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: pending set, offer flag, and the earliest edge at which
    // a new grant decision is allowed after an acceptance.
    logic [3:0] m_pend;
    int         m_rr;
    bit         m_vld;
    int         m_id;
    bit         m_pwr;
    int         m_drop;
    int         m_edge;
    int         m_earliest;

    int         acc_q[$];

    pb_cmd_sched #(.NUM_PB(Num), .GAP_CYCLES(Gap)) dut (
        .clk      (clk),
        .rst      (rst),
        .rel      (rel),
        .cmd_rdy  (cmd_rdy),
        .cmd_vld  (cmd_vld),
        .cmd_id   (cmd_id),
        .pend     (pend),
        .pwr_up   (pwr_up),
        .drop_cnt (drop_cnt)
    );

    pb_cmd_sched #(.NUM_PB(Num), .GAP_CYCLES(0)) dut_g0 (
        .clk      (clk),
        .rst      (rst),
        .rel      (rel0),
        .cmd_rdy  (rdy0),
        .cmd_vld  (vld0),
        .cmd_id   (id0),
        .pend     (pend0),
        .pwr_up   (pwr0),
        .drop_cnt (drop0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rd, input logic rs);
        bit         acc;
        logic [3:0] mask;
        logic [3:0] np;
        if (rs) begin
            m_pend     = '0;
            m_rr       = Num - 1;
            m_vld      = 0;
            m_id       = 0;
            m_pwr      = 0;
            m_drop     = 0;
            m_earliest = 0;
        end else begin
            acc  = m_vld && rd;
            mask = acc ? 4'(1 << m_id) : 4'b0;
            if (((r & m_pend & ~mask) != 4'b0) && (m_drop < 255)) m_drop++;
            np = (m_pend & ~mask) | r;
            if (acc) begin
                m_vld      = 0;
                m_rr       = m_id;
                if (m_id == 0) m_pwr = !m_pwr;
                m_earliest = m_edge + Gap + 1;
            end else if (!m_vld && (m_edge >= m_earliest) && (m_pend != 4'b0)) begin
                for (int k = 1; k <= Num; k++) begin
                    int j;
                    j = (m_rr + k) % Num;
                    if (!m_vld && m_pend[j]) begin
                        m_vld = 1;
                        m_id  = j;
                    end
                end
            end
            m_pend = np;
        end
        m_edge++;
    endtask

    // One clock: drive at negedge, advance the model on posedge, compare just after.
    task automatic step(input logic [3:0] r, input logic rd, input logic rs,
                        input logic [3:0] r0 = 4'b0);
        @(negedge clk);
        rel     = r;
        cmd_rdy = rd;
        rst     = rs;
        rel0    = r0;
        if (!rs && cmd_vld && rd) acc_q.push_back(int'(cmd_id));
        @(posedge clk);
        model_edge(r, rd, rs);
        #1;
        check("cmd_vld", cmd_vld, m_vld);
        if (m_vld) check("cmd_id", cmd_id, m_id);
        check("pend", pend, m_pend);
        check("pwr_up", pwr_up, m_pwr);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    initial begin
        rst     = 1'b1;
        rel     = '0;
        cmd_rdy = 1'b0;
        rel0    = '0;
        rdy0    = 1'b1;
        m_edge  = 0;

        // Reset and single event on button 2.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        check("rst_id", cmd_id, 0);
        step(4'b0100, 1'b1, 1'b0);
        check("single_pend", pend, 4'b0100);
        step(4'b0000, 1'b1, 1'b0);
        check("single_vld", cmd_vld, 1);
        check("single_id", cmd_id, 2);
        step(4'b0000, 1'b1, 1'b0);
        check("single_clr", pend, 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);

        // Round robin over all four buttons.
        step(4'b0000, 1'b0, 1'b1);
        acc_q.delete();
        step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(4'b0000, 1'b1, 1'b0);
        check("rr_count", acc_q.size(), 4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) check("rr_order", acc_q[i], i);
        check("rr_pwr", pwr_up, 1);
        acc_q.delete();
        step(4'b0011, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b0);
        check("rr2_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("rr2_first", acc_q[0], 0);
            check("rr2_second", acc_q[1], 1);
        end

        // Backpressure while id 1 is offered.
        step(4'b0000, 1'b0, 1'b1);
        acc_q.delete();
        step(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step((i % 3 == 0) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
        check("bp_id", cmd_id, 1);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b0);
        check("bp_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("bp_first", acc_q[0], 1);
            check("bp_second", acc_q[1], 3);
        end

        // Two drops on button 2 with the offer held.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("drop_two", drop_cnt, 2);

        // Release on the accepting edge of the same button is not a drop.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        check("acc_rel_pend", pend[1], 1);
        check("acc_rel_drop", drop_cnt, 0);

        // Saturation of the drop counter.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 301; i++) step(4'b0001, 1'b0, 1'b0);
        check("drop_sat", drop_cnt, 255);

        // Reset during GAP with pend=1010 and pwr_up=1.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1011, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("gap_pend", pend, 4'b1010);
        check("gap_pwr", pwr_up, 1);
        step(4'b0000, 1'b1, 1'b1);
        check("mid_rst_pwr", pwr_up, 0);
        check("mid_rst_pend", pend, 0);
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("mid_rst_first", cmd_id, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            logic       rd;
            logic       rs;
            r  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            rd = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 499) == 0);
            step(r, rd, rs);
        end

        // Zero-gap instance: two pending requests give vld 1,0,1.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 4'b0011);
        step(4'b0000, 1'b0, 1'b0);
        check("g0_vld0", vld0, 1);
        check("g0_id0", id0, 0);
        step(4'b0000, 1'b0, 1'b0);
        check("g0_vld1", vld0, 0);
        step(4'b0000, 1'b0, 1'b0);
        check("g0_vld2", vld0, 1);
        check("g0_id2", id0, 1);
        check("g0_pwr", pwr0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
